wg_slot_id_req_seq: RTL
=======================

# wg_slot_id_req_seq

Request sequencer that sits directly upstream of the WG slot-id converter in the CTA scheduler. It accepts allocate and deallocate requests through valid/ready handshakes and serialises them. It drives the converter's `generate`/`find_and_cancel` pulses with operands held stable for the converter's internal pipeline, and returns each result (wg id, cu id, slot id, fail flag) on a valid/ready response port. It also keeps a per-CU slot occupancy count, so it never issues an allocate to a full CU or a cancel to an empty one.

## Interface
- `NUMBER_CU`, 2, number of compute units.
- `CU_ID_WIDTH`, 1, CU index width.
- Widths `WG_ID_WIDTH` and `WG_SLOT_ID_WIDTH` come from `define.v`. `SLOT_NUM = 1 << WG_SLOT_ID_WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_valid_i` in 1 / `alloc_ready_o` out 1 / `alloc_wg_id_i` in `WG_ID_WIDTH` / `alloc_cu_id_i` in `CU_ID_WIDTH`: allocate request.
- `dealloc_valid_i` in 1 / `dealloc_ready_o` out 1 / `dealloc_wg_id_i` in `WG_ID_WIDTH` / `dealloc_cu_id_i` in `CU_ID_WIDTH`: deallocate request.
- `conv_wg_id_o` out `WG_ID_WIDTH` / `conv_cu_id_o` out `CU_ID_WIDTH`: operands to the converter.
- `conv_generate_o` out 1 / `conv_find_and_cancel_o` out 1: single-cycle pulses to the converter.
- `conv_slot_id_gen_i` in `WG_SLOT_ID_WIDTH` / `conv_slot_id_find_i` in `WG_SLOT_ID_WIDTH`: converter results.
- `resp_valid_o` out 1 / `resp_ready_i` in 1: response handshake.
- `resp_is_dealloc_o` out 1, `resp_fail_o` out 1, `resp_wg_id_o` out `WG_ID_WIDTH`, `resp_cu_id_o` out `CU_ID_WIDTH`, `resp_slot_id_o` out `WG_SLOT_ID_WIDTH`: response payload.

## Operation
- FSM states: IDLE, A_ISSUE, A_CAPT, D_SETUP, D_CANCEL, D_COMMIT, RESP.
- `alloc_ready_o` is 1 only in IDLE and only when `dealloc_valid_i` is 0. `dealloc_ready_o` is 1 only in IDLE. Deallocate always wins a simultaneous request.
- On any accept, latch wg_id and cu_id into the operand register. `conv_wg_id_o`/`conv_cu_id_o` are driven from this register and change only on an accept.
- Allocate accept:
  - If `cnt[cu] == SLOT_NUM`, go to RESP with fail=1, slot=0, and no converter pulse.
  - Otherwise go to A_ISSUE.
- A_ISSUE: `conv_generate_o` = 1 and `cnt[cu]` += 1. Go to A_CAPT.
- A_CAPT: capture `conv_slot_id_gen_i` into the response register. Go to RESP.
- Deallocate accept:
  - If `cnt[cu] == 0`, go to RESP with fail=1 and no pulse.
  - Otherwise go to D_SETUP.
- D_SETUP: no pulse. This lets the converter register the cu id before the CAM compare.
- D_CANCEL: `conv_find_and_cancel_o` = 1.
- D_COMMIT: no pulse, and in particular no generate, because the converter's generate would override its pending cancel. Capture `conv_slot_id_find_i`, `cnt[cu]` -= 1, go to RESP.
- RESP: `resp_valid_o` = 1 and the payload is stable. On `resp_ready_i` = 1, return to IDLE in the same edge. A new request is accepted the following cycle.
- Occupancy counters are `NUMBER_CU` × (`WG_SLOT_ID_WIDTH`+1) bits. They never wrap: full and empty requests are rejected as described above.
- An unknown wg_id on deallocate is not detected. The converter returns whatever it finds, and that value is reported unchanged.

## Timing
- Reset values: state IDLE, all counters 0, operand register 0, all `resp_*` outputs 0, `conv_*` pulses 0.
- Reset asserted mid-operation aborts the sequence immediately. The bench re-resets the converter together with this block.
- Allocate accepted at edge T:
  - `conv_generate_o` is high during cycle T+1.
  - The slot id is sampled during cycle T+2.
  - `resp_valid_o` is high from T+3.
- Deallocate accepted at edge T:
  - D_SETUP in T+1.
  - `conv_find_and_cancel_o` in T+2.
  - Find result sampled in T+3.
  - `resp_valid_o` from T+4.
- Rejected request: `resp_valid_o` is high from T+1.
- Operands are stable from T+1 until the next accept, which covers the converter's two-cycle hold requirement.
- Pulses are exactly one cycle. `conv_generate_o` and `conv_find_and_cancel_o` are never high together.
- Throughput is one request per 4 cycles (alloc) or 5 cycles (dealloc) with `resp_ready_i` tied high.

## Test plan
All scenarios use `WG_SLOT_ID_WIDTH`=3, so `SLOT_NUM`=8.
- Allocate wg 5, 9, 12 to CU0 back-to-back, ready=1 -> responses with slots 0, 1, 2, fail=0; each `conv_generate_o` pulse arrives 1 cycle after its accept.
- Deallocate wg 9 on CU0 -> `find_and_cancel` pulse 2 cycles after accept; response is_dealloc=1, slot=1. A following allocate of wg 20 to CU0 gets slot 1.
- Fill CU1 with 8 allocates, then a 9th -> fail=1 with no `generate` pulse; CU0 is unaffected.
- Deallocate to empty CU0 after reset -> fail=1, no pulse, counter stays 0.
- Alloc and dealloc valid in the same cycle -> dealloc accepted first, alloc accepted only after the dealloc response handshake.
- Hold `resp_ready_i`=0 for 10 cycles -> payload stable and both ready outputs low; assert reset mid-D_CANCEL -> all outputs return to their reset values.

Source files
------------

// File: rtl/wg_slot_id_req_seq.sv
// wg_slot_id_req_seq: serialises allocate/deallocate requests onto the WG slot-id converter,
// holding operands stable and tracking per-CU occupancy so full/empty requests never pulse it.
module wg_slot_id_req_seq #(
  parameter int NUMBER_CU        = 2,
  parameter int CU_ID_WIDTH      = 1,
  parameter int WG_ID_WIDTH      = 6,
  parameter int WG_SLOT_ID_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]      alloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]      alloc_cu_id_i,
  input  logic                        dealloc_valid_i,
  output logic                        dealloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]      dealloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]      dealloc_cu_id_i,
  output logic [WG_ID_WIDTH-1:0]      conv_wg_id_o,
  output logic [CU_ID_WIDTH-1:0]      conv_cu_id_o,
  output logic                        conv_generate_o,
  output logic                        conv_find_and_cancel_o,
  input  logic [WG_SLOT_ID_WIDTH-1:0] conv_slot_id_gen_i,
  input  logic [WG_SLOT_ID_WIDTH-1:0] conv_slot_id_find_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic                        resp_is_dealloc_o,
  output logic                        resp_fail_o,
  output logic [WG_ID_WIDTH-1:0]      resp_wg_id_o,
  output logic [CU_ID_WIDTH-1:0]      resp_cu_id_o,
  output logic [WG_SLOT_ID_WIDTH-1:0] resp_slot_id_o
);

  localparam int CNT_W = WG_SLOT_ID_WIDTH + 1;
  localparam logic [CNT_W-1:0] SLOT_NUM = {1'b1, {WG_SLOT_ID_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{WG_SLOT_ID_WIDTH{1'b0}}, 1'b1};
  localparam logic [WG_SLOT_ID_WIDTH-1:0] SLOT_ZERO = {WG_SLOT_ID_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_ISSUE  = 3'd1,
    A_CAPT   = 3'd2,
    D_SETUP  = 3'd3,
    D_CANCEL = 3'd4,
    D_COMMIT = 3'd5,
    RESP     = 3'd6
  } state_e;

  state_e                      state_q;
  logic [WG_ID_WIDTH-1:0]      op_wg_q;
  logic [CU_ID_WIDTH-1:0]      op_cu_q;
  logic [CNT_W-1:0]            cnt_q [NUMBER_CU];
  logic                        gen_q;
  logic                        cancel_q;
  logic                        resp_valid_q;
  logic                        resp_is_dealloc_q;
  logic                        resp_fail_q;
  logic [WG_ID_WIDTH-1:0]      resp_wg_q;
  logic [CU_ID_WIDTH-1:0]      resp_cu_q;
  logic [WG_SLOT_ID_WIDTH-1:0] resp_slot_q;
  logic [CNT_W-1:0]            alloc_cnt_s;
  logic [CNT_W-1:0]            dealloc_cnt_s;

  assign alloc_cnt_s   = cnt_q[alloc_cu_id_i];
  assign dealloc_cnt_s = cnt_q[dealloc_cu_id_i];

  // Deallocate has priority, so an allocate is only offered ready when no deallocate is pending.
  assign dealloc_ready_o = (state_q == IDLE);
  assign alloc_ready_o   = (state_q == IDLE) && !dealloc_valid_i;

  // Request sequencer FSM with registered converter pulses, operands and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      op_wg_q           <= {WG_ID_WIDTH{1'b0}};
      op_cu_q           <= {CU_ID_WIDTH{1'b0}};
      for (int i = 0; i < NUMBER_CU; i++) cnt_q[i] <= CNT_ZERO;
      gen_q             <= 1'b0;
      cancel_q          <= 1'b0;
      resp_valid_q      <= 1'b0;
      resp_is_dealloc_q <= 1'b0;
      resp_fail_q       <= 1'b0;
      resp_wg_q         <= {WG_ID_WIDTH{1'b0}};
      resp_cu_q         <= {CU_ID_WIDTH{1'b0}};
      resp_slot_q       <= SLOT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (dealloc_valid_i) begin
            op_wg_q <= dealloc_wg_id_i;
            op_cu_q <= dealloc_cu_id_i;
            if (dealloc_cnt_s == CNT_ZERO) begin
              state_q           <= RESP;
              resp_valid_q      <= 1'b1;
              resp_is_dealloc_q <= 1'b1;
              resp_fail_q       <= 1'b1;
              resp_wg_q         <= dealloc_wg_id_i;
              resp_cu_q         <= dealloc_cu_id_i;
              resp_slot_q       <= SLOT_ZERO;
            end else begin
              state_q <= D_SETUP;
            end
          end else if (alloc_valid_i) begin
            op_wg_q <= alloc_wg_id_i;
            op_cu_q <= alloc_cu_id_i;
            if (alloc_cnt_s == SLOT_NUM) begin
              state_q           <= RESP;
              resp_valid_q      <= 1'b1;
              resp_is_dealloc_q <= 1'b0;
              resp_fail_q       <= 1'b1;
              resp_wg_q         <= alloc_wg_id_i;
              resp_cu_q         <= alloc_cu_id_i;
              resp_slot_q       <= SLOT_ZERO;
            end else begin
              state_q <= A_ISSUE;
              gen_q   <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        A_ISSUE: begin
          gen_q          <= 1'b0;
          cnt_q[op_cu_q] <= cnt_q[op_cu_q] + CNT_ONE;
          state_q        <= A_CAPT;
        end
        A_CAPT: begin
          state_q           <= RESP;
          resp_valid_q      <= 1'b1;
          resp_is_dealloc_q <= 1'b0;
          resp_fail_q       <= 1'b0;
          resp_wg_q         <= op_wg_q;
          resp_cu_q         <= op_cu_q;
          resp_slot_q       <= conv_slot_id_gen_i;
        end
        // Idle cycle so the converter latches the cu id before its CAM compare.
        D_SETUP: begin
          cancel_q <= 1'b1;
          state_q  <= D_CANCEL;
        end
        D_CANCEL: begin
          cancel_q <= 1'b0;
          state_q  <= D_COMMIT;
        end
        D_COMMIT: begin
          cnt_q[op_cu_q]    <= cnt_q[op_cu_q] - CNT_ONE;
          state_q           <= RESP;
          resp_valid_q      <= 1'b1;
          resp_is_dealloc_q <= 1'b1;
          resp_fail_q       <= 1'b0;
          resp_wg_q         <= op_wg_q;
          resp_cu_q         <= op_cu_q;
          resp_slot_q       <= conv_slot_id_find_i;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          gen_q        <= 1'b0;
          cancel_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign conv_wg_id_o           = op_wg_q;
  assign conv_cu_id_o           = op_cu_q;
  assign conv_generate_o        = gen_q;
  assign conv_find_and_cancel_o = cancel_q;
  assign resp_valid_o           = resp_valid_q;
  assign resp_is_dealloc_o      = resp_is_dealloc_q;
  assign resp_fail_o            = resp_fail_q;
  assign resp_wg_id_o           = resp_wg_q;
  assign resp_cu_id_o           = resp_cu_q;
  assign resp_slot_id_o         = resp_slot_q;

endmodule
